// File: rtl/riscv_fpu_cmp_pipe.sv
// riscv_fpu_cmp_pipe
//   Pipelined non-arithmetic FP unit for RISC-V F/D: FEQ/FLT/FLE, FMIN/FMAX
//   and FSGNJ/FSGNJN/FSGNJX in single (NaN-boxed) and double precision.
//   All evaluation happens combinationally in front of the first register
//   stage; the remaining STAGES-1 stages only carry the result along.
//
// Parameters
//   XLEN   : datapath width, must be 64
//   STAGES : register stages from input to output, 1..4
//   TAG_W  : width of the opaque tag carried with each op
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : op handshake (in_ready = pipeline may advance)
//   op, is_double         : operation select, 1 = double operands
//   rs1_data, rs2_data    : operands
//   in_tag                : tag for the op
//   out_valid / out_ready : result handshake
//   result, flags, out_tag: result, fflags {NV,DZ,OF,UF,NX}, tag
//   flush                 : only when FPU_CMP_FLUSH_EN is defined; clears
//                           every stage and blocks acceptance that cycle
//
// Build option
//   FPU_CMP_FLUSH_EN : adds the flush input.

module riscv_fpu_cmp_pipe #(
    parameter int XLEN   = 64,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             is_double,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic [4:0]       flags,
    output logic [TAG_W-1:0] out_tag
`ifdef FPU_CMP_FLUSH_EN
    ,
    input  logic             flush
`endif
);

    localparam logic [2:0] OP_FSGNJ  = 3'b000;
    localparam logic [2:0] OP_FSGNJN = 3'b001;
    localparam logic [2:0] OP_FSGNJX = 3'b010;
    localparam logic [2:0] OP_FMIN   = 3'b011;
    localparam logic [2:0] OP_FMAX   = 3'b100;
    localparam logic [2:0] OP_FLE    = 3'b101;
    localparam logic [2:0] OP_FLT    = 3'b110;
    localparam logic [2:0] OP_FEQ    = 3'b111;

    localparam logic [31:0] QNAN_S = 32'h7FC0_0000;
    localparam logic [63:0] QNAN_D = 64'h7FF8_0000_0000_0000;

    logic w_flush;
`ifdef FPU_CMP_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Operand unboxing. In S mode the operand is kept in the low 32 bits
    // with the upper half zero so that the field extraction below can treat
    // both formats through the same muxes.
    // ------------------------------------------------------------------
    logic            w_box1_ok;
    logic            w_box2_ok;
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;

    assign w_box1_ok = &rs1_data[63:32];
    assign w_box2_ok = &rs2_data[63:32];
    assign w_a = is_double ? rs1_data : {32'h0, (w_box1_ok ? rs1_data[31:0] : QNAN_S)};
    assign w_b = is_double ? rs2_data : {32'h0, (w_box2_ok ? rs2_data[31:0] : QNAN_S)};

    logic        w_sign_a, w_sign_b;
    logic        w_exp1_a, w_exp1_b;
    logic        w_mnz_a,  w_mnz_b;
    logic        w_mmsb_a, w_mmsb_b;
    logic [62:0] w_mag_a,  w_mag_b;

    assign w_sign_a = is_double ? w_a[63]      : w_a[31];
    assign w_sign_b = is_double ? w_b[63]      : w_b[31];
    assign w_exp1_a = is_double ? &w_a[62:52]  : &w_a[30:23];
    assign w_exp1_b = is_double ? &w_b[62:52]  : &w_b[30:23];
    assign w_mnz_a  = is_double ? |w_a[51:0]   : |w_a[22:0];
    assign w_mnz_b  = is_double ? |w_b[51:0]   : |w_b[22:0];
    assign w_mmsb_a = is_double ? w_a[51]      : w_a[22];
    assign w_mmsb_b = is_double ? w_b[51]      : w_b[22];
    assign w_mag_a  = is_double ? w_a[62:0]    : {32'h0, w_a[30:0]};
    assign w_mag_b  = is_double ? w_b[62:0]    : {32'h0, w_b[30:0]};

    logic w_nan_a, w_nan_b, w_snan_a, w_snan_b;
    logic w_nan_any, w_snan_any;

    assign w_nan_a    = w_exp1_a & w_mnz_a;
    assign w_nan_b    = w_exp1_b & w_mnz_b;
    assign w_snan_a   = w_nan_a & ~w_mmsb_a;
    assign w_snan_b   = w_nan_b & ~w_mmsb_b;
    assign w_nan_any  = w_nan_a | w_nan_b;
    assign w_snan_any = w_snan_a | w_snan_b;

    // ------------------------------------------------------------------
    // Ordering. w_lt_tot is the sign-magnitude order with -0 < +0, which
    // is what FMIN/FMAX want; the compare ops override the zero case.
    // ------------------------------------------------------------------
    logic w_both_zero;
    logic w_mag_lt, w_mag_gt, w_mag_eq;
    logic w_lt_tot;
    logic w_eq, w_lt, w_le;

    assign w_both_zero = (w_mag_a == 63'h0) && (w_mag_b == 63'h0);
    assign w_mag_lt    = w_mag_a < w_mag_b;
    assign w_mag_gt    = w_mag_a > w_mag_b;
    assign w_mag_eq    = w_mag_a == w_mag_b;
    assign w_lt_tot    = (w_sign_a != w_sign_b) ? w_sign_a :
                         (w_sign_a ? w_mag_gt : w_mag_lt);

    assign w_eq = !w_nan_any && (w_both_zero || ((w_sign_a == w_sign_b) && w_mag_eq));
    assign w_lt = !w_nan_any && !w_both_zero && w_lt_tot;
    assign w_le = w_lt || w_eq;

    // ------------------------------------------------------------------
    // Result selection
    // ------------------------------------------------------------------
    logic            w_sgn;
    logic [XLEN-1:0] w_fp;
    logic [XLEN-1:0] w_canon;
    logic [XLEN-1:0] w_res;
    logic            w_nv;

    assign w_canon = is_double ? QNAN_D : {32'h0, QNAN_S};

    always_comb begin
        w_sgn = w_sign_b;
        w_fp  = '0;
        w_res = '0;
        w_nv  = 1'b0;

        case (op)
            OP_FSGNJN: w_sgn = ~w_sign_b;
            OP_FSGNJX: w_sgn = w_sign_a ^ w_sign_b;
            default:   w_sgn = w_sign_b;
        endcase

        if (op == OP_FMIN || op == OP_FMAX) begin
            if (w_nan_a && w_nan_b)
                w_fp = w_canon;
            else if (w_nan_a)
                w_fp = w_b;
            else if (w_nan_b)
                w_fp = w_a;
            else if (op == OP_FMIN)
                w_fp = w_lt_tot ? w_a : w_b;
            else
                w_fp = w_lt_tot ? w_b : w_a;
        end else begin
            w_fp = is_double ? {w_sgn, w_a[62:0]} : {32'h0, w_sgn, w_a[30:0]};
        end

        case (op)
            OP_FSGNJ, OP_FSGNJN, OP_FSGNJX: begin
                w_res = is_double ? w_fp : {32'hFFFF_FFFF, w_fp[31:0]};
            end
            OP_FMIN, OP_FMAX: begin
                w_res = is_double ? w_fp : {32'hFFFF_FFFF, w_fp[31:0]};
                w_nv  = w_snan_any;
            end
            OP_FLE: begin
                w_res = {63'h0, w_le};
                w_nv  = w_nan_any;
            end
            OP_FLT: begin
                w_res = {63'h0, w_lt};
                w_nv  = w_nan_any;
            end
            OP_FEQ: begin
                w_res = {63'h0, w_eq};
                w_nv  = w_snan_any;
            end
            default: begin
                w_res = '0;
                w_nv  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pipeline. All stages move together; bubbles are kept, so a stage's
    // data is only meaningful when its valid bit is set.
    // ------------------------------------------------------------------
    logic             r_vld [STAGES];
    logic [XLEN-1:0]  r_res [STAGES];
    logic [4:0]       r_flg [STAGES];
    logic [TAG_W-1:0] r_tag [STAGES];

    logic w_adv;
    logic w_accept;

    assign w_adv    = !r_vld[STAGES-1] || out_ready;
    assign in_ready = w_adv && !w_flush;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                r_vld[i] <= 1'b0;
                r_res[i] <= '0;
                r_flg[i] <= '0;
                r_tag[i] <= '0;
            end
        end else if (w_flush) begin
            for (int i = 0; i < STAGES; i++) begin
                r_vld[i] <= 1'b0;
            end
        end else if (w_adv) begin
            r_vld[0] <= w_accept;
            r_res[0] <= w_res;
            r_flg[0] <= {w_nv, 4'b0000};
            r_tag[0] <= in_tag;
            for (int i = 1; i < STAGES; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_res[i] <= r_res[i-1];
                r_flg[i] <= r_flg[i-1];
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign out_valid = r_vld[STAGES-1];
    assign result    = r_res[STAGES-1];
    assign flags     = r_flg[STAGES-1];
    assign out_tag   = r_tag[STAGES-1];

endmodule

// File: tb/tb_riscv_fpu_cmp_pipe.sv
module tb_riscv_fpu_cmp_pipe;

    localparam int XLEN   = 64;
    localparam int STAGES = 2;
    localparam int TAG_W  = 4;

    localparam logic [2:0] FSGNJ  = 3'b000;
    localparam logic [2:0] FSGNJN = 3'b001;
    localparam logic [2:0] FSGNJX = 3'b010;
    localparam logic [2:0] FMIN   = 3'b011;
    localparam logic [2:0] FMAX   = 3'b100;
    localparam logic [2:0] FLE    = 3'b101;
    localparam logic [2:0] FLT    = 3'b110;
    localparam logic [2:0] FEQ    = 3'b111;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic             is_double;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  result;
    logic [4:0]       flags;
    logic [TAG_W-1:0] out_tag;
    logic             flush;

    riscv_fpu_cmp_pipe #(.XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .is_double (is_double),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .out_tag   (out_tag)
`ifdef FPU_CMP_FLUSH_EN
        ,
        .flush     (flush)
`endif
    );

    typedef struct {
        logic [63:0] res;
        logic [4:0]  fl;
        logic [3:0]  tag;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic        d;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] r;
        logic [4:0]  f;
    } vec_t;

    exp_t sb[$];
    vec_t vt[$];
    vec_t bp[$];

    int n_vec  = 0;
    int n_miss = 0;
    int n_pop  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic add_vec(input logic [2:0] o, input logic d, input logic [63:0] a,
                           input logic [63:0] b, input logic [63:0] r, input logic [4:0] f);
        vec_t v;
        v.op = o; v.d = d; v.a = a; v.b = b; v.r = r; v.f = f;
        vt.push_back(v);
    endtask

    // Presents one op from the next negedge until it is accepted.
    task automatic issue(input logic [2:0] o, input logic d, input logic [63:0] a,
                         input logic [63:0] b, input logic [3:0] t,
                         input logic [63:0] er, input logic [4:0] ef);
        bit   done;
        exp_t e;
        done = 0;
        @(negedge clk);
        in_valid = 1'b1; op = o; is_double = d; rs1_data = a; rs2_data = b; in_tag = t;
        for (int k = 0; k < 20 && !done; k++) begin
            #1;
            if (in_ready) begin
                e.res = er; e.fl = ef; e.tag = t;
                sb.push_back(e);
                done = 1;
            end
            @(posedge clk);
            if (!done) @(negedge clk);
        end
        if (!done) begin
            n_vec++; n_miss++;
            $display("FAIL issue_timeout: tag %0d not accepted within 20 cycles", t);
        end
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 50) begin
            @(negedge clk);
            in_valid = 1'b0;
            k++;
        end
        chk(name, 64'(sb.size()), 64'd0);
    endtask

    // Scoreboard monitor: pops and compares every completed output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (out_valid && out_ready) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_miss++;
                    $display("FAIL unexpected_output: tag %0d result %h, none expected", out_tag, result);
                end else begin
                    e = sb.pop_front();
                    n_pop++;
                    if (result !== e.res || flags !== e.fl || out_tag !== e.tag) begin
                        n_miss++;
                        $display("FAIL out_check: got res=%h flags=%h tag=%0d, expected res=%h flags=%h tag=%0d",
                                 result, flags, out_tag, e.res, e.fl, e.tag);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, stall, pops0;
        bit seen, stalled;
        exp_t e;

        rst_n = 1'b0; in_valid = 1'b0; op = 3'b000; is_double = 1'b0;
        rs1_data = '0; rs2_data = '0; in_tag = '0; out_ready = 1'b1; flush = 1'b0;

        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_result",    result,         64'd0);
        chk("reset_flags",     64'(flags),     64'd0);
        chk("reset_out_tag",   64'(out_tag),   64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Latency: accepted at one edge, visible after STAGES edges.
        issue(FEQ, 1'b0, 64'hFFFFFFFF40000000, 64'hFFFFFFFF40000000, 4'd3, 64'h1, 5'h00);
        @(negedge clk); in_valid = 1'b0; #1;
        chk("latency_cycle1_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk); #1;
        chk("latency_cycle2_out_valid", 64'(out_valid), 64'd1);
        drain("latency_drain");

        // Directed vectors, issued back to back.
        add_vec(FLT,    1, 64'h7FF8000000000000, 64'h3FF0000000000000, 64'h0, 5'h10);
        add_vec(FEQ,    1, 64'h7FF8000000000000, 64'h3FF0000000000000, 64'h0, 5'h00);
        add_vec(FMIN,   0, 64'hFFFFFFFF80000000, 64'hFFFFFFFF00000000, 64'hFFFFFFFF80000000, 5'h00);
        add_vec(FMAX,   0, 64'hFFFFFFFF3F800000, 64'hFFFFFFFF7F800001, 64'hFFFFFFFF3F800000, 5'h10);
        add_vec(FSGNJN, 0, 64'h000000003F800000, 64'hFFFFFFFF3F800000, 64'hFFFFFFFFFFC00000, 5'h00);
        add_vec(FLE,    0, 64'hFFFFFFFF80000000, 64'hFFFFFFFF00000000, 64'h1, 5'h00);
        add_vec(FLT,    0, 64'hFFFFFFFF80000000, 64'hFFFFFFFF00000000, 64'h0, 5'h00);
        add_vec(FEQ,    0, 64'hFFFFFFFF80000000, 64'hFFFFFFFF00000000, 64'h1, 5'h00);
        add_vec(FEQ,    1, 64'h7FF0000000000001, 64'h3FF0000000000000, 64'h0, 5'h10);
        add_vec(FLT,    1, 64'h3FF0000000000000, 64'h4000000000000000, 64'h1, 5'h00);
        add_vec(FLT,    1, 64'hC000000000000000, 64'hBFF0000000000000, 64'h1, 5'h00);
        add_vec(FMIN,   1, 64'h7FF8000000000001, 64'hFFF8000000000000, 64'h7FF8000000000000, 5'h00);
        add_vec(FMAX,   1, 64'h3FF0000000000000, 64'hC008000000000000, 64'h3FF0000000000000, 5'h00);
        add_vec(FSGNJX, 1, 64'hC000000000000000, 64'hBFF0000000000000, 64'h4000000000000000, 5'h00);
        add_vec(FSGNJ,  0, 64'hFFFFFFFF3F800000, 64'hFFFFFFFFBF800000, 64'hFFFFFFFFBF800000, 5'h00);
        add_vec(FSGNJ,  0, 64'hFFFFFFFF7F800001, 64'hFFFFFFFF80000000, 64'hFFFFFFFFFF800001, 5'h00);
        add_vec(FMIN,   0, 64'hFFFFFFFF7FC00000, 64'hFFFFFFFF40400000, 64'hFFFFFFFF40400000, 5'h00);
        add_vec(FLE,    1, 64'h4000000000000000, 64'h4000000000000000, 64'h1, 5'h00);
        add_vec(FLE,    0, 64'hFFFFFFFF7FC00000, 64'hFFFFFFFF3F800000, 64'h0, 5'h10);
        add_vec(FEQ,    0, 64'h0000000040000000, 64'h0000000040000000, 64'h0, 5'h00);
        add_vec(FMAX,   0, 64'hFFFFFFFF80000000, 64'hFFFFFFFF00000000, 64'hFFFFFFFF00000000, 5'h00);

        foreach (vt[i])
            issue(vt[i].op, vt[i].d, vt[i].a, vt[i].b, 4'(i), vt[i].r, vt[i].f);
        drain("vectors_drain");

        // Backpressure: 4 FEQ ops, output stalled 3 cycles after first out_valid.
        add_vec(FEQ, 0, 64'hFFFFFFFF3F800000, 64'hFFFFFFFF3F800000, 64'h1, 5'h00);
        add_vec(FEQ, 0, 64'hFFFFFFFF3F800000, 64'hFFFFFFFF40000000, 64'h0, 5'h00);
        add_vec(FEQ, 1, 64'h4000000000000000, 64'h4000000000000000, 64'h1, 5'h00);
        add_vec(FEQ, 1, 64'h0000000000000000, 64'h8000000000000000, 64'h1, 5'h00);
        for (int i = vt.size() - 4; i < vt.size(); i++) bp.push_back(vt[i]);

        sent = 0; stall = 0; seen = 0; pops0 = n_pop;
        for (int cyc = 0; cyc < 40 && (sent < 4 || sb.size() != 0); cyc++) begin
            @(negedge clk);
            if (!seen && out_valid) begin seen = 1; stall = 3; end
            if (stall > 0) begin out_ready = 1'b0; stall--; stalled = 1; end
            else begin out_ready = 1'b1; stalled = 0; end
            if (sent < 4) begin
                in_valid = 1'b1; op = bp[sent].op; is_double = bp[sent].d;
                rs1_data = bp[sent].a; rs2_data = bp[sent].b; in_tag = 4'(sent + 1);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (stalled) begin
                chk("stall_in_ready",  64'(in_ready),  64'd0);
                chk("stall_out_valid", 64'(out_valid), 64'd1);
                chk("stall_out_tag",   64'(out_tag),   64'd1);
                chk("stall_result",    result,         64'h1);
            end
            if (in_valid && in_ready) begin
                e.res = bp[sent].r; e.fl = bp[sent].f; e.tag = 4'(sent + 1);
                sb.push_back(e);
                sent++;
            end
        end
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
        chk("bp_ops_sent", 64'(sent), 64'd4);
        chk("bp_ops_retired", 64'(n_pop - pops0), 64'd4);
        drain("bp_drain");

        // Asynchronous reset with two ops in flight.
        issue(FEQ, 0, 64'hFFFFFFFF3F800000, 64'hFFFFFFFF3F800000, 4'd9,  64'h1, 5'h00);
        issue(FEQ, 0, 64'hFFFFFFFF3F800000, 64'hFFFFFFFF3F800000, 4'd10, 64'h1, 5'h00);
        @(negedge clk); in_valid = 1'b0; #1;
        chk("pre_reset_out_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_out_valid", 64'(out_valid), 64'd0);
        chk("async_reset_result",    result,         64'd0);
        chk("async_reset_out_tag",   64'(out_tag),   64'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("post_reset_idle", 64'(out_valid), 64'd0);
        end

`ifdef FPU_CMP_FLUSH_EN
        issue(FEQ, 0, 64'hFFFFFFFF3F800000, 64'hFFFFFFFF3F800000, 4'd11, 64'h1, 5'h00);
        issue(FEQ, 0, 64'hFFFFFFFF3F800000, 64'hFFFFFFFF3F800000, 4'd12, 64'h1, 5'h00);
        @(negedge clk);
        out_ready = 1'b0; flush = 1'b1; in_tag = 4'd13; in_valid = 1'b1;
        #1;
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        sb.delete();
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("post_flush_idle", 64'(out_valid), 64'd0);
        end
`endif

        repeat (2) @(negedge clk);
        chk("final_scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/riscv_fpu_cmp_pipe.md
Name: riscv_fpu_cmp_pipe

Overview:
Pipelined, parametrised non-arithmetic FP unit covering RISC-V F/D compare (FEQ/FLT/FLE), min/max (FMIN/FMAX) and sign injection (FSGNJ/FSGNJN/FSGNJX) in single and double precision.
It offloads these ops from riscv_fpu into a valid/ready-handshaked pipeline of configurable depth with tag passthrough, so the core can issue one op per cycle and retire results in order.
It sits beside riscv_fpu in the FP execute stage.

Parameters:
XLEN, 64, datapath width; must be 64 (holds NaN-boxed single or a double)
STAGES, 2, register stages from input to output; legal 1..4
TAG_W, 4, width of opaque tag carried alongside each op

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  op presented
in_ready  output  1  pipeline accepts op this cycle
op  input  3  000 FSGNJ, 001 FSGNJN, 010 FSGNJX, 011 FMIN, 100 FMAX, 101 FLE, 110 FLT, 111 FEQ
is_double  input  1  1 = D operands, 0 = S (NaN-boxed)
rs1_data  input  XLEN  operand 1
rs2_data  input  XLEN  operand 2
in_tag  input  TAG_W  tag for this op
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  XLEN  result
flags  output  5  fflags {NV,DZ,OF,UF,NX}; only NV ever set
out_tag  output  TAG_W  tag of result
flush  input  1  present only with FPU_CMP_FLUSH_EN

Behaviour:
- Reset (async, rst_n low): every stage valid cleared; out_valid=0, result=0, flags=0, out_tag=0. Ops in flight are discarded. No output pulse after release.
- Advance = !out_valid || out_ready. All stages shift together on advance. in_ready = advance (combinational).
- Accept on in_valid && in_ready. Bubbles are not collapsed.
- Latency: exactly STAGES cycles from accept to out_valid with no stall. Throughput: 1 op/cycle.
- Output hold: while out_valid && !out_ready, result/flags/out_tag are held stable. Ops are never dropped or reordered.
- Unboxing (S mode): an operand whose bits [63:32] are not all ones is treated as canonical NaN 0x7FC00000.
- NaN classes: qNaN has MSB of mantissa set; sNaN has exp all ones, MSB of mantissa clear, mantissa nonzero.
- Canonical NaN: S = 0x7FC00000; D = 0x7FF8000000000000.
- FEQ: result 1 if equal, with +0 == -0. Result 0 if either operand is NaN. NV only if either operand is sNaN.
- FLT/FLE: signed-magnitude ordering, with -0 == +0 (FLT(-0,+0)=0, FLE=1). Any NaN gives result 0 and NV.
- Compare results are zero-extended to XLEN (not NaN-boxed).
- FMIN/FMAX operand selection:
  - one operand NaN: return the other;
  - both NaN: return canonical NaN;
  - -0 is treated as less than +0.
- FMIN/FMAX NV: set if either operand is sNaN.
- FSGNJ/FSGNJN/FSGNJX: magnitude from rs1 (after unboxing). Sign = rs2 sign / inverted rs2 sign / XOR of the two signs. No flags, no NaN canonicalisation.
- S-mode FP results (min/max/sgnj) are NaN-boxed: {32'hFFFFFFFF, res32}.
- Combinational evaluation sits in the first stage; remaining stages are pure registers.
- is_double and op are sampled at accept only.

Optional Feature:
FPU_CMP_FLUSH_EN: adds the flush input.
- flush high at a clock edge clears all stage valids (incl. output) in the same edge; any op offered that cycle is not accepted (in_ready forced 0 while flush=1).
- Next cycle out_valid=0.
- flush has priority over advance.
Without the macro: no flush port; ops leave only via out_valid/out_ready.

Test Plan:
- STAGES=2, out_ready=1: FEQ S, rs1=rs2=0xFFFFFFFF40000000, tag 3 -> 2 cycles later out_valid=1, result=0x1, flags=0, out_tag=3.
- FLT D, rs1=0x7FF8000000000000, rs2=0x3FF0000000000000 -> result=0, flags=0x10. Same operands with FEQ -> result=0, flags=0x00.
- Min/max edge cases:
  - FMIN S (0xFFFFFFFF80000000, 0xFFFFFFFF00000000) -> 0xFFFFFFFF80000000, flags 0;
  - FMAX S (0xFFFFFFFF3F800000, 0xFFFFFFFF7F800001) -> 0xFFFFFFFF3F800000, flags 0x10.
- FSGNJN S, rs1=0x000000003F800000 (bad box), rs2=0xFFFFFFFF3F800000 -> 0xFFFFFFFFFFC00000, flags 0.
- Backpressure: 4 back-to-back FEQ ops with tags 1..4; hold out_ready=0 for 3 cycles after first out_valid.
  - in_ready=0 during the stall; result/out_tag stable.
  - Tags emerge 1,2,3,4 in order, none lost or duplicated.
- Reset with 2 ops in flight -> out_valid=0 immediately (async). After release, idle inputs give no out_valid for 5 cycles. With FPU_CMP_FLUSH_EN: flush with 2 ops in flight -> out_valid=0 next cycle, those tags never appear.
